ex_mem_stage_reg: RTL and testbench
===================================

Name: ex_mem_stage_reg

Overview:
- Parametrised EX/MEM pipeline register for the five-stage MIPS core; successor to the fixed-width EX-to-MEM latch.
- Adds per-stage valid bit, stall (hold) and flush (bubble) controls, and load size/sign fields.
- Tnew countdown now always reloads and saturates at 0.
- Generates an M-stage forwarding qualifier and a saturating stall-cycle counter for the hazard unit and debug.

Parameters:
DATA_W, 32, width of ALU result and store data
REG_W, 5, register-address width
TNEW_W, 2, width of Tnew field
CNT_W, 16, width of stall-cycle counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
stall_M  in  1  hold all M-stage contents
flush_M  in  1  load a bubble into M
validE  in  1  EX holds a real instruction
regwriteE  in  1  register write enable
memtoregE  in  1  writeback from memory
memwriteE  in  1  memory store
mem_sizeE  in  2  0=byte, 1=half, 2=word, 3=reserved
load_signedE  in  1  sign-extend load
rtE  in  REG_W  rt field
write_regE  in  REG_W  destination register
alu_outE  in  DATA_W  ALU result / address
write_dataE  in  DATA_W  store data
Tnew_E  in  TNEW_W  cycles until result ready, seen in EX
validM  out  1  M holds a real instruction
regwriteM  out  1  registered
memtoregM  out  1  registered
memwriteM  out  1  registered
mem_sizeM  out  2  registered
load_signedM  out  1  registered
rtM  out  REG_W  registered
write_regM  out  REG_W  registered
alu_outM  out  DATA_W  registered
write_dataM  out  DATA_W  registered
Tnew_M  out  TNEW_W  remaining latency in M
fwd_validM  out  1  alu_outM may be forwarded
stall_cnt  out  CNT_W  saturating count of stall_M cycles

Behaviour:
- Reset is synchronous, active-high, sampled on rising clk. Every registered output goes to 0: validM, all control bits, mem_sizeM, rtM, write_regM, alu_outM, write_dataM, Tnew_M, stall_cnt. reset has top priority.
- Priority per edge: reset > flush_M > stall_M > load.
- Flush: validM, regwriteM, memtoregM and memwriteM go to 0, and Tnew_M goes to 0. Data, address and size fields go to 0. A flush with stall_M also high still flushes.
- Stall (flush_M=0): every field, including Tnew_M, holds its value. Tnew does not decrement while held.
- Load (neither asserted):
  - All fields take their E values with 1-cycle latency.
  - Tnew_M <= (Tnew_E > 0) ? Tnew_E - 1 : 0. Tnew_M never wraps or holds stale data when Tnew_E=0.
  - If validE=0, the control bits regwriteM, memtoregM and memwriteM are forced to 0. Data fields still load.
- fwd_validM is combinational from the registered outputs: validM & regwriteM & ~memtoregM & (write_regM != 0) & (Tnew_M == 0).
- stall_cnt:
  - Increments by 1 on each edge where stall_M=1, flush_M=0 and reset=0.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared only by reset; unaffected by flush.
- mem_sizeE=3 passes through unchanged. Decoding is the memory stage's job.
- Widths are exact. No truncation apart from the Tnew decrement, which is done in TNEW_W bits.

Test Plan:
- Reset: drive all inputs nonzero, set reset=1 for one edge → every output is 0, including stall_cnt and fwd_validM. Release reset with validE=1, alu_outE=0x1234_5678, regwriteE=1, write_regE=5, Tnew_E=0 → next edge gives alu_outM=0x12345678, validM=1, Tnew_M=0, fwd_validM=1.
- Tnew countdown: Tnew_E=2 → Tnew_M=1. Next load with Tnew_E=0, starting from Tnew_M=1 → Tnew_M=0, not held at 1. With Tnew_E=1, memtoregE=1 → Tnew_M=0 and fwd_validM=0.
- Stall: load write_dataM=0xDEADBEEF, then hold stall_M=1 for 3 cycles while changing the E inputs → all M outputs are unchanged and stall_cnt=3. Release stall → new E values load on the next edge.
- Flush priority: stall_M=1 and flush_M=1 with regwriteE=1, memwriteE=1 → validM=0, regwriteM=0, memwriteM=0, Tnew_M=0, and stall_cnt does not increment.
- Invalid and r0: validE=0, regwriteE=1 → regwriteM=0, fwd_validM=0. validE=1, write_regE=0, regwriteE=1 → regwriteM=1, fwd_validM=0.
- Counter saturation: CNT_W=3, hold stall_M=1 for 10 cycles → stall_cnt stops at 7. Reset mid-stall → stall_cnt=0 on that edge.

Source files
------------

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register: carries EX results into the memory stage with a
// valid bit, hold/bubble controls, a saturating Tnew countdown, an M-stage
// forwarding qualifier and a saturating stall-cycle counter.
module ex_mem_stage_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned TNEW_W = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_M,
    input  logic              flush_M,
    input  logic              validE,
    input  logic              regwriteE,
    input  logic              memtoregE,
    input  logic              memwriteE,
    input  logic [1:0]        mem_sizeE,
    input  logic              load_signedE,
    input  logic [REG_W-1:0]  rtE,
    input  logic [REG_W-1:0]  write_regE,
    input  logic [DATA_W-1:0] alu_outE,
    input  logic [DATA_W-1:0] write_dataE,
    input  logic [TNEW_W-1:0] Tnew_E,
    output logic              validM,
    output logic              regwriteM,
    output logic              memtoregM,
    output logic              memwriteM,
    output logic [1:0]        mem_sizeM,
    output logic              load_signedM,
    output logic [REG_W-1:0]  rtM,
    output logic [REG_W-1:0]  write_regM,
    output logic [DATA_W-1:0] alu_outM,
    output logic [DATA_W-1:0] write_dataM,
    output logic [TNEW_W-1:0] Tnew_M,
    output logic              fwd_validM,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              r_valid;
    logic              r_regwrite;
    logic              r_memtoreg;
    logic              r_memwrite;
    logic [1:0]        r_mem_size;
    logic              r_load_signed;
    logic [REG_W-1:0]  r_rt;
    logic [REG_W-1:0]  r_write_reg;
    logic [DATA_W-1:0] r_alu_out;
    logic [DATA_W-1:0] r_write_data;
    logic [TNEW_W-1:0] r_tnew;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic [TNEW_W-1:0] w_tnew_next;
    logic              w_fwd_valid;

    // Tnew decrement in TNEW_W bits, clamped at zero so it never wraps.
    always_comb begin
        w_tnew_next = '0;
        if (Tnew_E != '0) begin
            w_tnew_next = Tnew_E - TNEW_W'(1);
        end
    end

    // Pipeline fields: reset > flush (bubble) > stall (hold) > load.
    always_ff @(posedge clk) begin
        if (reset || flush_M) begin
            r_valid       <= 1'b0;
            r_regwrite    <= 1'b0;
            r_memtoreg    <= 1'b0;
            r_memwrite    <= 1'b0;
            r_mem_size    <= '0;
            r_load_signed <= 1'b0;
            r_rt          <= '0;
            r_write_reg   <= '0;
            r_alu_out     <= '0;
            r_write_data  <= '0;
            r_tnew        <= '0;
        end else if (!stall_M) begin
            r_valid       <= validE;
            r_regwrite    <= validE & regwriteE;
            r_memtoreg    <= validE & memtoregE;
            r_memwrite    <= validE & memwriteE;
            r_mem_size    <= mem_sizeE;
            r_load_signed <= load_signedE;
            r_rt          <= rtE;
            r_write_reg   <= write_regE;
            r_alu_out     <= alu_outE;
            r_write_data  <= write_dataE;
            r_tnew        <= w_tnew_next;
        end
    end

    // Stall-cycle counter: counts held cycles only, saturates, ignores flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (stall_M && !flush_M && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    // Forwarding qualifier from registered M-stage state.
    always_comb begin
        w_fwd_valid = r_valid & r_regwrite & ~r_memtoreg
                      & (r_write_reg != '0) & (r_tnew == '0);
    end

    assign validM       = r_valid;
    assign regwriteM    = r_regwrite;
    assign memtoregM    = r_memtoreg;
    assign memwriteM    = r_memwrite;
    assign mem_sizeM    = r_mem_size;
    assign load_signedM = r_load_signed;
    assign rtM          = r_rt;
    assign write_regM   = r_write_reg;
    assign alu_outM     = r_alu_out;
    assign write_dataM  = r_write_data;
    assign Tnew_M       = r_tnew;
    assign fwd_validM   = w_fwd_valid;
    assign stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Self-checking bench for ex_mem_stage_reg: directed scenarios plus random
// traffic, checked against a behavioural model of the M-stage contents.
module tb_ex_mem_stage_reg;

    logic        clk = 1'b0;
    logic        reset, stall_M, flush_M, validE, regwriteE, memtoregE, memwriteE;
    logic [1:0]  mem_sizeE;
    logic        load_signedE;
    logic [4:0]  rtE, write_regE;
    logic [31:0] alu_outE, write_dataE;
    logic [1:0]  Tnew_E;

    logic        validM, regwriteM, memtoregM, memwriteM, load_signedM, fwd_validM;
    logic [1:0]  mem_sizeM, Tnew_M;
    logic [4:0]  rtM, write_regM;
    logic [31:0] alu_outM, write_dataM;
    logic [15:0] stall_cnt;

    logic        s_validM, s_regwriteM, s_memtoregM, s_memwriteM, s_load_signedM, s_fwd_validM;
    logic [1:0]  s_mem_sizeM, s_Tnew_M;
    logic [4:0]  s_rtM, s_write_regM;
    logic [31:0] s_alu_outM, s_write_dataM;
    logic [2:0]  s_stall_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    // behavioural model of M-stage contents
    bit        m_valid, m_rw, m_mtr, m_mw, m_ls;
    bit [1:0]  m_size;
    bit [4:0]  m_rt, m_wr;
    bit [31:0] m_alu, m_wd;
    int        m_tnew, m_cnt16, m_cnt3;

    always #5 clk = ~clk;

    ex_mem_stage_reg #(.DATA_W(32), .REG_W(5), .TNEW_W(2), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .stall_M(stall_M), .flush_M(flush_M),
        .validE(validE), .regwriteE(regwriteE), .memtoregE(memtoregE),
        .memwriteE(memwriteE), .mem_sizeE(mem_sizeE), .load_signedE(load_signedE),
        .rtE(rtE), .write_regE(write_regE), .alu_outE(alu_outE),
        .write_dataE(write_dataE), .Tnew_E(Tnew_E),
        .validM(validM), .regwriteM(regwriteM), .memtoregM(memtoregM),
        .memwriteM(memwriteM), .mem_sizeM(mem_sizeM), .load_signedM(load_signedM),
        .rtM(rtM), .write_regM(write_regM), .alu_outM(alu_outM),
        .write_dataM(write_dataM), .Tnew_M(Tnew_M), .fwd_validM(fwd_validM),
        .stall_cnt(stall_cnt)
    );

    ex_mem_stage_reg #(.DATA_W(32), .REG_W(5), .TNEW_W(2), .CNT_W(3)) dut_small (
        .clk(clk), .reset(reset), .stall_M(stall_M), .flush_M(flush_M),
        .validE(validE), .regwriteE(regwriteE), .memtoregE(memtoregE),
        .memwriteE(memwriteE), .mem_sizeE(mem_sizeE), .load_signedE(load_signedE),
        .rtE(rtE), .write_regE(write_regE), .alu_outE(alu_outE),
        .write_dataE(write_dataE), .Tnew_E(Tnew_E),
        .validM(s_validM), .regwriteM(s_regwriteM), .memtoregM(s_memtoregM),
        .memwriteM(s_memwriteM), .mem_sizeM(s_mem_sizeM), .load_signedM(s_load_signedM),
        .rtM(s_rtM), .write_regM(s_write_regM), .alu_outM(s_alu_outM),
        .write_dataM(s_write_dataM), .Tnew_M(s_Tnew_M), .fwd_validM(s_fwd_validM),
        .stall_cnt(s_stall_cnt)
    );

    function automatic logic [98:0] dut_vec();
        return {validM, regwriteM, memtoregM, memwriteM, mem_sizeM, load_signedM,
                rtM, write_regM, alu_outM, write_dataM, Tnew_M, stall_cnt};
    endfunction

    function automatic logic [98:0] exp_vec();
        logic [1:0]  t;
        logic [15:0] c;
        t = 2'(m_tnew);
        c = 16'(m_cnt16);
        return {m_valid, m_rw, m_mtr, m_mw, m_size, m_ls, m_rt, m_wr, m_alu, m_wd, t, c};
    endfunction

    function automatic bit exp_fwd();
        return m_valid && m_rw && !m_mtr && (m_wr != 0) && (m_tnew == 0);
    endfunction

    // Apply one clock edge to the model from the currently driven inputs.
    task automatic model_edge();
        if (reset) begin
            {m_valid, m_rw, m_mtr, m_mw, m_ls} = '0;
            m_size = 0; m_rt = 0; m_wr = 0; m_alu = 0; m_wd = 0; m_tnew = 0;
            m_cnt16 = 0; m_cnt3 = 0;
        end else if (flush_M) begin
            {m_valid, m_rw, m_mtr, m_mw, m_ls} = '0;
            m_size = 0; m_rt = 0; m_wr = 0; m_alu = 0; m_wd = 0; m_tnew = 0;
        end else if (stall_M) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt3 < 7) m_cnt3++;
        end else begin
            m_valid = validE;
            m_rw    = validE && regwriteE;
            m_mtr   = validE && memtoregE;
            m_mw    = validE && memwriteE;
            m_size  = mem_sizeE;
            m_ls    = load_signedE;
            m_rt    = rtE;
            m_wr    = write_regE;
            m_alu   = alu_outE;
            m_wd    = write_dataE;
            m_tnew  = (int'(Tnew_E) > 0) ? int'(Tnew_E) - 1 : 0;
        end
    endtask

    task automatic clock();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rand_e();
        validE       = 1'($urandom);
        regwriteE    = 1'($urandom);
        memtoregE    = 1'($urandom);
        memwriteE    = 1'($urandom);
        mem_sizeE    = 2'($urandom);
        load_signedE = 1'($urandom);
        rtE          = 5'($urandom);
        write_regE   = 5'($urandom_range(0, 3) == 0 ? 0 : $urandom);
        alu_outE     = $urandom;
        write_dataE  = $urandom;
        Tnew_E       = 2'($urandom);
    endtask

    task automatic test_reset();
        reset = 1; stall_M = 1; flush_M = 0;
        validE = 1; regwriteE = 1; memtoregE = 1; memwriteE = 1; mem_sizeE = 3;
        load_signedE = 1; rtE = 5'h1f; write_regE = 5'h1f; alu_outE = '1;
        write_dataE = '1; Tnew_E = 3;
        clock();
        n_cmp++;
        if (dut_vec() !== 99'd0) begin
            n_fail++; $display("FAIL reset_fields got=%h exp=0", dut_vec());
        end
        n_cmp++;
        if (fwd_validM !== 1'b0 || s_stall_cnt !== 3'd0) begin
            n_fail++; $display("FAIL reset_fwd_cnt got=%b/%0d exp=0/0", fwd_validM, s_stall_cnt);
        end
        reset = 0; stall_M = 0; memtoregE = 0; memwriteE = 0;
        alu_outE = 32'h1234_5678; write_regE = 5; Tnew_E = 0;
        clock();
        n_cmp++;
        if ({alu_outM, validM, Tnew_M, fwd_validM} !== {32'h1234_5678, 1'b1, 2'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL first_load got alu=%h v=%b t=%0d fwd=%b exp alu=12345678 v=1 t=0 fwd=1",
                     alu_outM, validM, Tnew_M, fwd_validM);
        end
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL first_load_all got=%h exp=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_tnew();
        int tv[4]  = '{2, 0, 1, 3};
        int exp[4] = '{1, 0, 0, 2};
        validE = 1; regwriteE = 1; write_regE = 7; memtoregE = 0;
        for (int i = 0; i < 4; i++) begin
            Tnew_E = 2'(tv[i]);
            memtoregE = (i == 2);
            clock();
            n_cmp++;
            if (int'(Tnew_M) != exp[i]) begin
                n_fail++; $display("FAIL tnew_%0d got=%0d exp=%0d", i, Tnew_M, exp[i]);
            end
            n_cmp++;
            if (fwd_validM !== exp_fwd()) begin
                n_fail++; $display("FAIL tnew_fwd_%0d got=%b exp=%b", i, fwd_validM, exp_fwd());
            end
        end
    endtask

    task automatic test_stall();
        logic [98:0] held;
        int          cnt0;
        rand_e(); write_dataE = 32'hDEAD_BEEF;
        clock();
        held = exp_vec();
        cnt0 = m_cnt16;
        stall_M = 1;
        for (int i = 0; i < 3; i++) begin
            rand_e();
            clock();
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL stall_hold_%0d got=%h exp=%h", i, dut_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (write_dataM !== 32'hDEAD_BEEF || int'(stall_cnt) != cnt0 + 3 || dut_vec()[98:16] !== held[98:16]) begin
            n_fail++; $display("FAIL stall_summary got wd=%h cnt=%0d exp wd=deadbeef cnt=%0d",
                               write_dataM, stall_cnt, cnt0 + 3);
        end
        stall_M = 0;
        rand_e();
        clock();
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL stall_release got=%h exp=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_flush();
        int cnt0;
        rand_e(); validE = 1; Tnew_E = 3;
        clock();
        cnt0 = m_cnt16;
        stall_M = 1; flush_M = 1; regwriteE = 1; memwriteE = 1;
        clock();
        n_cmp++;
        if ({validM, regwriteM, memwriteM, Tnew_M} !== 5'd0 || int'(stall_cnt) != cnt0) begin
            n_fail++; $display("FAIL flush_prio got v=%b rw=%b mw=%b t=%0d cnt=%0d exp 0 0 0 0 cnt=%0d",
                               validM, regwriteM, memwriteM, Tnew_M, stall_cnt, cnt0);
        end
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL flush_all got=%h exp=%h", dut_vec(), exp_vec());
        end
        stall_M = 0; flush_M = 0;
    endtask

    task automatic test_invalid_r0();
        rand_e(); validE = 0; regwriteE = 1; memtoregE = 0; write_regE = 9; Tnew_E = 0;
        clock();
        n_cmp++;
        if (regwriteM !== 1'b0 || fwd_validM !== 1'b0 || alu_outM !== m_alu) begin
            n_fail++; $display("FAIL invalid got rw=%b fwd=%b alu=%h exp rw=0 fwd=0 alu=%h",
                               regwriteM, fwd_validM, alu_outM, m_alu);
        end
        validE = 1; write_regE = 0;
        clock();
        n_cmp++;
        if (regwriteM !== 1'b1 || fwd_validM !== 1'b0) begin
            n_fail++; $display("FAIL r0 got rw=%b fwd=%b exp rw=1 fwd=0", regwriteM, fwd_validM);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rand_e();
            reset   = ($urandom_range(0, 49) == 0);
            flush_M = ($urandom_range(0, 9) == 0);
            stall_M = ($urandom_range(0, 3) == 0);
            clock();
            n_cmp++;
            if (dut_vec() !== exp_vec() || fwd_validM !== exp_fwd()) begin
                n_fail++; $display("FAIL random_%0d got=%h fwd=%b exp=%h fwd=%b",
                                   i, dut_vec(), fwd_validM, exp_vec(), exp_fwd());
            end
            n_cmp++;
            if (int'(s_stall_cnt) != m_cnt3) begin
                n_fail++; $display("FAIL random_cnt3_%0d got=%0d exp=%0d", i, s_stall_cnt, m_cnt3);
            end
        end
        reset = 0; flush_M = 0; stall_M = 0;
    endtask

    task automatic test_saturation();
        reset = 1;
        clock();
        reset = 0; stall_M = 1;
        for (int i = 0; i < 10; i++) clock();
        n_cmp++;
        if (s_stall_cnt !== 3'd7 || int'(s_stall_cnt) != m_cnt3) begin
            n_fail++; $display("FAIL sat_cnt3 got=%0d exp=7", s_stall_cnt);
        end
        n_cmp++;
        if (stall_cnt !== 16'd10) begin
            n_fail++; $display("FAIL sat_cnt16 got=%0d exp=10", stall_cnt);
        end
        reset = 1;
        clock();
        n_cmp++;
        if (s_stall_cnt !== 3'd0 || stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL sat_reset got=%0d/%0d exp=0/0", s_stall_cnt, stall_cnt);
        end
        reset = 0; stall_M = 0;
    endtask

    initial begin
        reset = 1; stall_M = 0; flush_M = 0;
        rand_e();
        #2;
        test_reset();
        test_tnew();
        test_stall();
        test_flush();
        test_invalid_r0();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
